// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: instruction/flag inputs and control-word outputs
// of the microcode sequencer. The master side (CPU datapath or bench)
// drives insn and flags. The slave side (sequencer) drives ctrl and step.
interface microcode_sequencer_if #(
    parameter int INSN_W = 8,
    parameter int STEPS  = 5
);
    localparam int SW = $clog2(STEPS);

    logic [INSN_W-1:0] insn;
    logic              carry_flag;
    logic              zero_flag;
    logic [15:0]       ctrl;
    logic [SW-1:0]     step;

    modport master (output insn, carry_flag, zero_flag, input ctrl, step);
    modport slave  (input insn, carry_flag, zero_flag, output ctrl, step);
endinterface

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: falling-edge microcode sequencer for the 8-bit
// breadboard CPU. It drives one registered 16-bit control word per
// micro-step and can end an instruction early at its first empty execute step.
// Optional feature macro: MICROSEQ_COND_JUMP_EN enables the flag-conditional
// jumps (JC/JZ) and the flags-in strobe (fi) on ADD/SUB.
// ctrl bits [15:0] = hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
module microcode_sequencer #(
    parameter int INSN_W    = 8,
    parameter int OPCODE_W  = 4,
    parameter int STEPS     = 5,
    parameter int EARLY_END = 1
) (
    input logic clk,
    input logic rst,
    microcode_sequencer_if.slave bus
);
    localparam int SW = $clog2(STEPS);

`ifdef MICROSEQ_COND_JUMP_EN
    localparam logic COND_EN = 1'b1;
`else
    localparam logic COND_EN = 1'b0;
`endif

    localparam logic [15:0] FI_BIT  = COND_EN ? 16'h0001 : 16'h0000;
    localparam logic [15:0] FETCH0  = 16'h4004;  // mi|co
    localparam logic [15:0] FETCH1  = 16'h1408;  // ro|ii|ce
    localparam logic [15:0] MI_IO   = 16'h4800;
    localparam logic [15:0] RO_AI   = 16'h1200;
    localparam logic [15:0] RO_BI   = 16'h1020;
    localparam logic [15:0] EO_AI   = 16'h0280;
    localparam logic [15:0] EO_SU   = 16'h02C0;
    localparam logic [15:0] AO_RI   = 16'h2100;
    localparam logic [15:0] IO_AI   = 16'h0A00;
    localparam logic [15:0] IO_J    = 16'h0802;
    localparam logic [15:0] AO_OI   = 16'h0110;
    localparam logic [15:0] HLT     = 16'h8000;

    localparam logic [SW-1:0] S0 = SW'(0);
    localparam logic [SW-1:0] S1 = SW'(1);
    localparam logic [SW-1:0] S2 = SW'(2);
    localparam logic [SW-1:0] S3 = SW'(3);
    localparam logic [SW-1:0] S4 = SW'(4);

    logic [SW-1:0]       step_q, step_nxt;
    logic [15:0]         ctrl_q, ctrl_nxt;
    logic [SW:0]         inc;
    logic [OPCODE_W-1:0] opc;
    logic [3:0]          op;
    logic                op_hi;
    logic                cf, zf;
    logic                unused_insn;

    assign opc = bus.insn[INSN_W-1 -: OPCODE_W];
    assign op  = opc[3:0];
    // low operand bits are carried in insn but never decoded here
    assign unused_insn = ^bus.insn;

    // opcodes wider than 4 bits with any upper bit set decode as NOP
    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_hi = |opc[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign op_hi = 1'b0;
        end
    endgenerate

`ifdef MICROSEQ_COND_JUMP_EN
    assign cf = bus.carry_flag;
    assign zf = bus.zero_flag;
`else
    logic unused_flags;
    assign cf = 1'b0;
    assign zf = 1'b0;
    assign unused_flags = bus.carry_flag ^ bus.zero_flag;
`endif

    // control word for micro-step k of opcode op under the given flags
    function automatic logic [15:0] decode(input logic [SW-1:0] k, input logic [3:0] o,
                                           input logic hi, input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        if (k == S0)      w = FETCH0;
        else if (k == S1) w = FETCH1;
        else if (!hi) begin
            case (o)
                4'h1: if (k == S2) w = MI_IO; else if (k == S3) w = RO_AI;
                4'h2: if (k == S2) w = MI_IO; else if (k == S3) w = RO_BI;
                      else if (k == S4) w = EO_AI | FI_BIT;
                4'h3: if (k == S2) w = MI_IO; else if (k == S3) w = RO_BI;
                      else if (k == S4) w = EO_SU | FI_BIT;
                4'h4: if (k == S2) w = MI_IO; else if (k == S3) w = AO_RI;
                4'h5: if (k == S2) w = IO_AI;
                4'h6: if (k == S2) w = IO_J;
                4'h7: if (COND_EN && k == S2 && c) w = IO_J;
                4'h8: if (COND_EN && k == S2 && z) w = IO_J;
                4'hE: if (k == S2) w = AO_OI;
                4'hF: if (k == S2) w = HLT;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    // next step: wrap at STEPS, and optionally skip the empty tail of an instruction
    always_comb begin
        inc      = {1'b0, step_q} + (SW+1)'(1);
        step_nxt = inc[SW-1:0];
        if (inc == (SW+1)'(STEPS))
            step_nxt = '0;
        if (EARLY_END != 0 && step_nxt >= S2 &&
            decode(step_nxt, op, op_hi, cf, zf) == 16'h0000)
            step_nxt = '0;
    end

    // control word for the step being entered, from the current insn and flags
    always_comb begin
        ctrl_nxt = decode(step_nxt, op, op_hi, cf, zf);
    end

    // falling-edge state register; hlt in the current word freezes everything
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            ctrl_q <= FETCH0;
        end else if (!ctrl_q[15]) begin
            step_q <= step_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    assign bus.step = step_q;
    assign bus.ctrl = ctrl_q;
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microcode sequencer for the 8-bit breadboard-style CPU. It replaces the fixed five-step control decoder with a configurable step count and early instruction termination. It adds the full instruction set, including store, immediate load, subtract and jumps, with optional flag-conditional jumps. It sits between the instruction register and the bus/ALU/memory control pins and drives one 16-bit control word per micro-step.

## Interface
- INSN_W, 8, instruction register width
- OPCODE_W, 4, opcode width; opcode = insn[INSN_W-1 -: OPCODE_W]; legal 4..INSN_W
- STEPS, 5, micro-steps per instruction (legal 5..8); step counter width SW = $clog2(STEPS)
- EARLY_END, 1, 1 = terminate an instruction at its first all-zero execute step
- clk  in  1  system clock; all state updates on the falling edge
- rst  in  1  reset, asynchronous, active-high
- insn  in  INSN_W  current instruction register contents
- carry_flag  in  1  latched ALU carry flag
- zero_flag  in  1  latched ALU zero flag
- ctrl  out  16  registered control word, bits [15:0] = hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
- step  out  SW  current micro-step index (debug / LED)

## Operation
- Fetch steps, same for all opcodes:
  - step 0: mi|co = 0x4004
  - step 1: ro|ii|ce = 0x1408
- Execute steps 2..4, by opcode (all unlisted steps = 0):
  - NOP (0x0): all zero
  - LDA (0x1): 2 mi|io 0x4800; 3 ro|ai 0x1200
  - ADD (0x2): 2 0x4800; 3 ro|bi 0x1020; 4 eo|ai|fi 0x0281
  - SUB (0x3): as ADD, step 4 eo|ai|su|fi 0x02C1
  - STA (0x4): 2 0x4800; 3 ao|ri 0x2100
  - LDI (0x5): 2 io|ai 0x0A00
  - JMP (0x6): 2 io|j 0x0802
  - JC (0x7): 2 0x0802 if carry_flag, else 0
  - JZ (0x8): 2 0x0802 if zero_flag, else 0
  - OUT (0xE): 2 ao|oi 0x0110
  - HLT (0xF): 2 hlt 0x8000
  - all other opcodes, including any opcode value ≥ 16 when OPCODE_W > 4: NOP
- Steps 5..STEPS-1 always decode to 0.
- Next-step rule, on each falling edge with current step s:
  - n = s+1.
  - If n == STEPS, then n = 0.
  - If EARLY_END=1, n ≥ 2 and decode(n) == 0, then n = 0.
  - Then step <= n and ctrl <= decode(n, opcode, flags).
- insn, carry_flag and zero_flag are sampled at the falling edge that computes ctrl. They are not re-sampled within a step.
- Halt:
  - Once ctrl[15] = 1, step and ctrl freeze. Only rst leaves halt.
  - Flag and insn changes during halt are ignored.

## Timing
- Reset values: step = 0, ctrl = 0x4004. Both are applied immediately on rst assertion, independent of clk.
- The first falling edge after rst deasserts moves to step 1 (0x1408).
- ctrl changes only on falling edges. It is stable across the following rising edge, where the bus and registers latch.
- Instruction length with EARLY_END=1: NOP 2 cycles; LDI, JMP, OUT, untaken JC/JZ 3; LDA, STA 4; ADD, SUB 5.
- With EARLY_END=0, every instruction takes STEPS cycles.
- JC/JZ evaluate the flag at the falling edge ending step 1. The flags must be valid then.
- rst asserted mid-instruction aborts it. Partial control words are never emitted.
- A rst release coincident with a falling edge is a don't-care. The bench keeps them ≥ 1 ns apart.

## Configuration
- MICROSEQ_COND_JUMP_EN defined:
  - JC/JZ behave as specified above.
  - fi (ctrl[0]) is asserted on ADD/SUB step 4.
- Not defined:
  - JC and JZ decode as NOP; the flag inputs are unused.
  - ctrl[0] is constant 0, so ADD step 4 = 0x0280 and SUB step 4 = 0x02C0.

## Test plan
- Reset: assert rst mid-clock → ctrl = 0x4004 and step = 0 immediately. Release, then one falling edge → 0x1408.
- LDA (insn 0x1E), EARLY_END=1 → ctrl sequence 0x4004, 0x1408, 0x4800, 0x1200, then 0x4004 (4-cycle instruction).
- SUB (insn 0x3F), macro defined → 0x4004, 0x1408, 0x4800, 0x1020, 0x02C1, then wrap to 0x4004.
- JC (insn 0x73), macro defined:
  - carry_flag = 1 → step 2 = 0x0802.
  - carry_flag = 0 → step 2 skipped, 0x4004 after 0x1408.
  - Macro undefined → always skipped.
- HLT (insn 0xF0) → 0x8000 held for 20 cycles with toggling insn and flags. Then rst → 0x4004.
- STEPS=8, EARLY_END=0, OUT (insn 0xE0) → 0x4004, 0x1408, 0x0110, then five zero steps, then 0x4004. step counts 0..7.
